// File: rtl/ras_ckpt.sv
// Return-address stack for the fetch stage: circular entry array with pointer and occupancy,
// overflow/underflow pulses, same-cycle push bypass and checkpoint restore on flush.
module ras_ckpt #(
    parameter  int DW         = 64,
    parameter  int DEPTH      = 16,
    parameter  int BYPASS     = 1,
    parameter  int RESTORE_OP = 1,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          stall_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          flush_i,
    input  logic [PW-1:0] flush_ptr_i,
    input  logic [CW-1:0] flush_cnt_i,
    output logic [DW-1:0] top_data_o,
    output logic          top_vld_o,
    output logic [PW-1:0] ckpt_ptr_o,
    output logic [CW-1:0] ckpt_cnt_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          pshEff, popEff, bypassEn, wrEn;
    logic [PW-1:0] baseP, wrAddr, topIdx;
    logic [CW-1:0] baseC;

    // Next state is computed from the restored checkpoint when flushing, otherwise from the live state
    always_comb begin
        pshEff   = push_i & ~stall_i;
        popEff   = pop_i & ~stall_i;
        baseP    = flush_i ? flush_ptr_i : ptr_q;
        baseC    = flush_i ? ((flush_cnt_i > FULL) ? FULL : flush_cnt_i) : cnt_q;
        ptr_d    = baseP;
        cnt_d    = baseC;
        wrEn     = 1'b0;
        wrAddr   = baseP;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        if (!flush_i || (RESTORE_OP != 0)) begin
            if (pshEff && popEff && (baseC != '0)) begin
                wrEn   = 1'b1;
                wrAddr = baseP - PW'(1);
            end else if (pshEff) begin
                wrEn   = 1'b1;
                wrAddr = baseP;
                ptr_d  = baseP + PW'(1);
                if (baseC == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = baseC + CW'(1);
                end
            end else if (popEff) begin
                if (baseC != '0) begin
                    ptr_d = baseP - PW'(1);
                    cnt_d = baseC - CW'(1);
                end else begin
                    udf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            if (wrEn) begin
                mem_q[wrAddr] <= push_data_i;
            end
        end
    end

    // Top view follows the registered pointer; a flush becomes visible one cycle later
    always_comb begin
        bypassEn   = (BYPASS != 0) && pshEff && !flush_i;
        topIdx     = ptr_q - PW'(1);
        top_data_o = bypassEn ? push_data_i : mem_q[topIdx];
        top_vld_o  = (cnt_q != '0) | bypassEn;
    end

    assign ckpt_ptr_o = ptr_d;
    assign ckpt_cnt_o = cnt_d;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;

endmodule
